// File: rtl/pwr_est.sv
// I/Q window power estimator: windowed mean of i^2+q^2, log2 via leading-one + LUT, scaled to 0.125 dB.
// Optional PWR_EST_IIR_EN adds a first-order smoother on the dB output.
module pwr_est #(
    parameter int IQ_W     = 10,
    parameter int WIN_LOG2 = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   est_ena,
    input  logic                   iq_val,
    input  logic signed [IQ_W-1:0] i_in,
    input  logic signed [IQ_W-1:0] q_in,
    output logic [2*IQ_W-1:0]      pwr_mean,
    output logic [8:0]             pwr_est_dB,
    output logic                   pwr_est_end
);
    localparam int PW = 2 * IQ_W;
    localparam int AW = PW + WIN_LOG2;
    localparam int EW = $clog2(PW);

    logic [AW-1:0]       acc_q, acc_d, acc_sum;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [PW-1:0]       mean_q, mean_d;
    logic                s0_q, s0_d, s1_q, s2_q, end_q;
    logic [8:0]          log_q, log_d;
    logic [8:0]          x_q, x_d;
    logic [8:0]          db_q, db_d;

    logic signed [PW-1:0] i_ext, q_ext, i_sq, q_sq;
    logic [PW-1:0]        p;
    logic                 accept;

    // Squares are never negative and their sum cannot exceed 2^(PW-1).
    always_comb begin
        i_ext   = PW'(i_in);
        q_ext   = PW'(q_in);
        i_sq    = i_ext * i_ext;
        q_sq    = q_ext * q_ext;
        p       = i_sq + q_sq;
        accept  = est_ena & iq_val;
        acc_sum = acc_q + AW'(p);
    end

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        mean_d = mean_q;
        s0_d   = 1'b0;
        if (!est_ena) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (&cnt_q) begin
                acc_d  = '0;
                cnt_d  = '0;
                mean_d = PW'(acc_sum >> WIN_LOG2);
                s0_d   = 1'b1;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    function automatic logic [3:0] log2_frac(input logic [3:0] m);
        case (m)
            4'd0:  log2_frac = 4'd0;
            4'd1:  log2_frac = 4'd1;
            4'd2:  log2_frac = 4'd3;
            4'd3:  log2_frac = 4'd4;
            4'd4:  log2_frac = 4'd5;
            4'd5:  log2_frac = 4'd6;
            4'd6:  log2_frac = 4'd7;
            4'd7:  log2_frac = 4'd8;
            4'd8:  log2_frac = 4'd9;
            4'd9:  log2_frac = 4'd10;
            4'd10: log2_frac = 4'd11;
            4'd11: log2_frac = 4'd12;
            4'd12: log2_frac = 4'd13;
            4'd13: log2_frac = 4'd14;
            default: log2_frac = 4'd15;
        endcase
    endfunction

    logic [PW+2:0] padded;
    logic [EW-1:0] lead_e;
    logic [3:0]    mant;

    // Padding on the right supplies the zero fill for mantissa bits when e < 4.
    always_comb begin
        padded = {mean_q[PW-2:0], 4'b0000};
        lead_e = '0;
        mant   = '0;
        for (int b = 0; b < PW; b++) begin
            if (mean_q[b]) begin
                lead_e = EW'(b);
                mant   = padded[b +: 4];
            end
        end
        if (mean_q == '0)
            log_d = '0;
        else
            log_d = 9'({lead_e, 4'b0000}) + 9'(log2_frac(mant));
        // 385/256 ~ 10*log10(2)*8/16, rounded to nearest.
        x_d = 9'((17'(log_q) * 17'd385 + 17'd128) >> 8);
    end

`ifdef PWR_EST_IIR_EN
    logic                first_q;
    logic signed [9:0]   diff, step;
    logic signed [10:0]  smooth;

    always_comb begin
        diff   = $signed({1'b0, x_q}) - $signed({1'b0, db_q});
        step   = diff >>> 2;
        smooth = $signed({2'b00, db_q}) + $signed({step[9], step});
        if (first_q)
            db_d = x_q;
        else if (smooth[10])
            db_d = '0;
        else if (smooth[9])
            db_d = 9'd511;
        else
            db_d = smooth[8:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            first_q <= 1'b1;
        else if (!est_ena)
            first_q <= 1'b1;
        else if (s2_q)
            first_q <= 1'b0;
    end
`else
    always_comb db_d = x_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            mean_q <= '0;
            s0_q   <= 1'b0;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            end_q  <= 1'b0;
            log_q  <= '0;
            x_q    <= '0;
            db_q   <= '0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            mean_q <= mean_d;
            s0_q   <= s0_d;
            s1_q   <= est_ena & s0_q;
            s2_q   <= est_ena & s1_q;
            end_q  <= est_ena & s2_q;
            if (s0_q)
                log_q <= log_d;
            if (s1_q)
                x_q <= x_d;
            if (est_ena & s2_q)
                db_q <= db_d;
        end
    end

    assign pwr_mean    = mean_q;
    assign pwr_est_dB  = db_q;
    assign pwr_est_end = end_q;
endmodule

// File: doc/pwr_est.md
Name: pwr_est

Overview:
- Upstream power estimator for the AGC loop; feeds the PWM gain-control stage.
- Accumulates instantaneous I/Q power over a fixed window of 2^WIN_LOG2 valid samples and takes the mean.
- Converts the mean to dB (LSB 0.125 dB, 9-bit unsigned) using leading-one detection and a 16-entry log2 LUT.
- Emits pwr_est_dB with a single-cycle pwr_est_end strobe per window.

Parameters:
- IQ_W, 10, signed I/Q sample width.
- WIN_LOG2, 8, log2 of the averaging window length in samples (legal range 2..12).

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- est_ena  input  1  estimator enable; low clears window state
- iq_val  input  1  I/Q sample valid qualifier
- i_in  input  IQ_W  signed in-phase sample
- q_in  input  IQ_W  signed quadrature sample
- pwr_mean  output  2*IQ_W  latched linear mean power of the last completed window
- pwr_est_dB  output  9  power estimate, unsigned, 0.125 dB/LSB
- pwr_est_end  output  1  one-cycle strobe: pwr_est_dB updated

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. While reset is asserted, all outputs, the accumulator, the sample counter and the pipeline valids are 0.
- Instantaneous power: p = i*i + q*q, unsigned, 2*IQ_W bits. No overflow is possible; max is 2^(2*IQ_W-1) at i=q=-2^(IQ_W-1).
- Accumulator width is 2*IQ_W+WIN_LOG2 bits. Sample counter is WIN_LOG2 bits and wraps.
- Sample acceptance:
  - On each clk with est_ena & iq_val, add p to the accumulator and increment the counter.
  - When the counter is all-ones on an accepted sample (the last sample of the window):
    - stage0 valid is set;
    - the mean (acc + p) >> WIN_LOG2 is latched into pwr_mean;
    - the accumulator is cleared and the counter wraps to 0 in the same cycle.
  - The next window starts with no gap.
- Stage 1 (log2), one cycle after stage 0:
  - e = bit index of the leading one of pwr_mean (0..2*IQ_W-1).
  - m = the 4 bits below the leading one, zero-padded on the right when e<4.
  - L = e*16 + LUT[m], 9 bits.
  - LUT[0..15] = 0,1,3,4,5,6,7,8,9,10,11,12,13,14,15,15.
  - pwr_mean == 0 forces L=0.
- Stage 2 (scale), one cycle after stage 1:
  - dB = (L*385 + 128) >> 8, truncated to 9 bits.
  - Register into pwr_est_dB and pulse pwr_est_end for exactly one cycle.
- Latency: pwr_est_end is asserted 3 clk edges after the edge that accepts the last sample of a window.
- pwr_est_dB and pwr_mean hold their values between strobes.
- est_ena low:
  - accumulator and counter are cleared;
  - stage valids are cleared, so no strobe is issued for in-flight data;
  - pwr_est_dB and pwr_mean hold.
- est_ena rising: the window restarts from sample 0; the partial window from before disable is discarded.
- iq_val low: no accumulation; the pipeline still advances. Gaps in iq_val only stretch the window.
- Reset mid-window: all state returns to reset values immediately.

Optional Feature:
- Macro: PWR_EST_IIR_EN.
- Defined:
  - Stage 2 output is smoothed: y <= y + ((x - y) >>> 2), using 10-bit signed difference and arithmetic shift, with the result clamped to 0..511.
  - The first strobe after reset or after est_ena rising loads y = x directly.
  - Latency and strobe timing are unchanged; pwr_est_dB = y.
- Undefined: pwr_est_dB = x (raw per-window estimate). No smoothing register is present.

Test Plan:
- IQ_W=10, WIN_LOG2=4, i=q=0 continuous -> strobe every 16 valid cycles, pwr_est_dB=0, pwr_mean=0.
- i=256, q=0 continuous -> pwr_mean=65536, L=256, pwr_est_dB=385 (48.125 dB); strobe 3 cycles after the 16th sample.
- i=q=-512 continuous -> pwr_mean=524288, L=304, pwr_est_dB=457; no overflow.
- i=3, q=0 continuous -> pwr_mean=9, e=3, m=2, L=51, pwr_est_dB=77.
- iq_val toggled 50%, with est_ena dropped after 10 samples and re-raised -> no strobe for the aborted window; next strobe after 16 fresh valid samples; pwr_est_dB held at its previous value meanwhile.
- PWR_EST_IIR_EN defined, windows of dB 385 then 77 -> outputs 385, then 385 + ((77-385)>>>2) = 308.
